// File: rtl/ascon_pack.sv
// Shared ASCON types: permutation state, FSM encoding, mode codes,
// the round-constant table and small helpers used by the round datapath.
package ascon_pack;

    // Five 64-bit words; index 0 is x0, index 4 is x4.
    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Round-count selection on mode_i.
    localparam logic [1:0] MODE_P12  = 2'b00;
    localparam logic [1:0] MODE_P8   = 2'b01;
    localparam logic [1:0] MODE_P6   = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // Every schedule ends after round 11, so the counter stops at 12.
    localparam logic [3:0] ROUND_END = 4'd12;

    // Round constant XORed into the low byte of x2.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        case (r)
            4'd0:    return 8'hF0;
            4'd1:    return 8'hE1;
            4'd2:    return 8'hD2;
            4'd3:    return 8'hC3;
            4'd4:    return 8'hB4;
            4'd5:    return 8'hA5;
            4'd6:    return 8'h96;
            4'd7:    return 8'h87;
            4'd8:    return 8'h78;
            4'd9:    return 8'h69;
            4'd10:   return 8'h5A;
            4'd11:   return 8'h4B;
            default: return 8'h00;
        endcase
    endfunction

    // Shorter permutations use the tail of the 12-round schedule;
    // the reserved code falls back to the full permutation.
    function automatic logic [3:0] first_round(input logic [1:0] mode);
        case (mode)
            MODE_P8: return 4'd4;
            MODE_P6: return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    // Rotate right; only ever called with constant amounts in 1..63.
    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One ASCON round, purely combinational: constant addition, bit-sliced
// 5-bit S-box layer, then per-word linear diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state,
    input  logic [3:0] round_idx,
    output type_state  result
);

    // Rotation pairs for the diffusion of x0..x4.
    localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

    type_state   sbox_out;
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    // Constant addition followed by the bit-sliced S-box applied to all 64 columns.
    always_comb begin
        x0 = state[0];
        x1 = state[1];
        x2 = state[2] ^ {56'd0, round_const(round_idx)};
        x3 = state[3];
        x4 = state[4];

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;

        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;

        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;

        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        sbox_out[0] = x0;
        sbox_out[1] = x1;
        sbox_out[2] = x2;
        sbox_out[3] = x3;
        sbox_out[4] = x4;
    end

    // Linear diffusion: each word mixes with two rotated copies of itself.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_diffuse
            assign result[gi] = sbox_out[gi]
                              ^ ror64(sbox_out[gi], ROT_A[gi])
                              ^ ror64(sbox_out[gi], ROT_B[gi]);
        end
    endgenerate

endmodule

// File: rtl/ascon_permutation_seq.sv
// Sequential ASCON permutation: UNROLL rounds per clock (1 or 2), with
// a start/busy/done handshake and a 12, 8 or 6 round schedule.
module ascon_permutation_seq
    import ascon_pack::*;
#(
    // Rounds per clock; only 1 and 2 divide every schedule evenly.
    parameter int UNROLL = 1
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic [1:0] mode_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [3:0] STEP = 4'(UNROLL);

    fsm_state_e fsm_reg, fsm_next;
    logic [3:0] round_reg, round_next;
    type_state  state_reg, state_next;

    // chain[0] is the registered state; chain[UNROLL] is after the last round this cycle.
    type_state  chain [UNROLL+1];

    assign chain[0] = state_reg;

    genvar gi;
    generate
        for (gi = 0; gi < UNROLL; gi++) begin : g_round
            ascon_round u_round (
                .state     (chain[gi]),
                .round_idx (round_reg + 4'(gi)),
                .result    (chain[gi+1])
            );
        end
    endgenerate

    // FSM, round counter and working state register.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_reg   <= ST_IDLE;
            round_reg <= 4'd0;
            state_reg <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            round_reg <= round_next;
            state_reg <= state_next;
        end
    end

    // Next-state logic: load on an accepted start, advance UNROLL rounds per RUN cycle.
    always_comb begin
        fsm_next   = fsm_reg;
        round_next = round_reg;
        state_next = state_reg;
        busy_o     = 1'b0;
        done_o     = 1'b0;

        case (fsm_reg)
            ST_IDLE, ST_DONE: begin
                done_o = (fsm_reg == ST_DONE);
                if (start_i) begin
                    state_next = state_i;
                    round_next = first_round(mode_i);
                    fsm_next   = ST_RUN;
                end else begin
                    fsm_next   = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_o     = 1'b1;
                state_next = chain[UNROLL];
                round_next = round_reg + STEP;
                if (round_next == ROUND_END) begin
                    fsm_next = ST_DONE;
                end
            end
            default: begin
                fsm_next = ST_IDLE;
            end
        endcase
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_ascon_permutation_seq.sv
// Bench for ascon_permutation_seq: one UNROLL=1 and one UNROLL=2 instance
// share stimulus; a table-driven ASCON model predicts results and latency,
// and a monitor checks every done_o pulse against the expected queue.
module tb_ascon_permutation_seq;
    import ascon_pack::*;

    typedef struct {
        type_state st;
        int        lat;
        int        acc;
    } exp_t;

    logic       clk;
    logic       resetb;
    logic       start;
    logic [1:0] mode;
    type_state  state_in;
    type_state  st_o [2];
    logic       busy [2];
    logic       done [2];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rem [2]  = '{0, 0};
    int   unr [2]  = '{1, 2};
    exp_t q [2][$];

    // ASCON 5-bit S-box, input x0 as MSB.
    logic [4:0] sbox_tab [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    ascon_permutation_seq #(.UNROLL(1)) u1 (
        .clock_i(clk), .resetb_i(resetb), .start_i(start), .mode_i(mode),
        .state_i(state_in), .state_o(st_o[0]), .busy_o(busy[0]), .done_o(done[0]));

    ascon_permutation_seq #(.UNROLL(2)) u2 (
        .clock_i(clk), .resetb_i(resetb), .start_i(start), .mode_i(mode),
        .state_i(state_in), .state_o(st_o[1]), .busy_o(busy[1]), .done_o(done[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ror(logic [63:0] x, int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic type_state model_round(type_state s, int r);
        type_state  t;
        logic [4:0] col;
        logic [4:0] o;
        logic [7:0] rc;
        rc = 8'hF0 - 8'(r) * 8'h0F;
        s[2][7:0] = s[2][7:0] ^ rc;
        for (int b = 0; b < 64; b++) begin
            col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
            o = sbox_tab[col];
            t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
        end
        for (int i = 0; i < 5; i++)
            s[i] = t[i] ^ ror(t[i], rot_a[i]) ^ ror(t[i], rot_b[i]);
        return s;
    endfunction

    function automatic type_state model_perm(type_state s, int first, int n);
        for (int r = first; r < first + n; r++) s = model_round(s, r);
        return s;
    endfunction

    function automatic int rounds_of(logic [1:0] m);
        return (m == 2'b01) ? 8 : (m == 2'b10) ? 6 : 12;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    // Advance one clock; predict which instance accepts the current start.
    task automatic step();
        int   n;
        exp_t e;
        if (resetb) begin
            for (int k = 0; k < 2; k++) begin
                if (rem[k] > 0) begin
                    rem[k]--;
                end else if (start) begin
                    n     = rounds_of(mode);
                    e.st  = model_perm(state_in, 12 - n, n);
                    e.lat = n / unr[k];
                    e.acc = cyc + 1;
                    q[k].push_back(e);
                    rem[k] = n / unr[k];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q[0].size() != 0 || q[1].size() != 0); i++) step();
        step();
        checks++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending u1=%0d u2=%0d required 0", q[0].size(), q[1].size());
        end
    endtask

    task automatic check_idle(string name);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (st_o[k] !== '0 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
                failures++;
                $display("FAIL %s u%0d state=%h busy=%b done=%b required zero", name, k + 1,
                         st_o[k], busy[k], done[k]);
            end
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result and latency.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (done[k] === 1'b1) begin
                checks++;
                if (q[k].size() == 0) begin
                    failures++;
                    $display("FAIL u%0d_spurious_done at cycle %0d required no done", k + 1, cyc);
                end else begin
                    e = q[k].pop_front();
                    if (st_o[k] !== e.st || (cyc - e.acc) != e.lat) begin
                        failures++;
                        $display("FAIL u%0d_result state=%h lat=%0d required state=%h lat=%0d",
                                 k + 1, st_o[k], cyc - e.acc, e.st, e.lat);
                    end else begin
                        $display("u%0d done lat=%0d x0=%h", k + 1, e.lat, e.st[0]);
                    end
                end
            end
        end
    end

    initial begin
        type_state kat;
        type_state exp1;
        kat[0] = 64'h80400c0600000000;
        kat[1] = 64'h0001020304050607;
        kat[2] = 64'h08090a0b0c0d0e0f;
        kat[3] = 64'h0011223344556677;
        kat[4] = 64'h8899aabbccddeeff;

        resetb = 1'b0; start = 1'b0; mode = 2'b00; state_in = '0;
        #1;
        check_idle("reset_async");
        for (int i = 0; i < 3; i++) step();
        resetb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("idle_after_reset");
        end

        // Known-answer vector, full permutation, first-round intermediate check.
        state_in = kat; mode = 2'b00; start = 1'b1;
        step();
        start = 1'b0; state_in = rand_state();
        step();
        for (int k = 0; k < 2; k++) begin
            exp1 = model_perm(kat, 0, unr[k]);
            checks++;
            if (st_o[k] !== exp1) begin
                failures++;
                $display("FAIL u%0d_first_edge state=%h required %h", k + 1, st_o[k], exp1);
            end
        end
        drain();

        // Same vector through the shorter schedules and the reserved mode.
        for (int m = 1; m < 4; m++) begin
            state_in = kat; mode = 2'(m); start = 1'b1;
            step();
            start = 1'b0;
            drain();
        end

        // Start pulse in the middle of a run must be ignored.
        state_in = rand_state(); mode = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        state_in = rand_state(); mode = 2'b10; start = 1'b1;
        step();
        start = 1'b0;
        drain();

        // Start held high: back-to-back runs with no idle gap.
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            state_in = rand_state();
            mode = 2'($urandom_range(0, 3));
            step();
        end
        start = 1'b0;
        drain();

        // Random runs with random gaps.
        for (int j = 0; j < 15; j++) begin
            state_in = rand_state();
            mode = 2'($urandom_range(0, 3));
            start = 1'b1;
            step();
            start = 1'b0;
            for (int i = 0; i < int'($urandom_range(0, 14)); i++) step();
        end
        drain();

        // Reset at RUN cycle 3 abandons the run.
        state_in = kat; mode = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #2;
        resetb = 1'b0;
        #1;
        check_idle("reset_mid_run");
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            rem[k] = 0;
        end
        step();
        step();
        resetb = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            check_idle("no_done_after_reset");
        end

        // Fresh start completes normally after the abandoned run.
        state_in = kat; mode = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ascon_permutation_seq.md
ASCON_PERMUTATION_SEQ -- requirements
Module: ascon_permutation_seq

Interface
REQ-001 Parameter UNROLL, default 1, meaning rounds applied per clock cycle; legal values 1 and 2 only.
REQ-002 clock_i  input  1  system clock; all state updates on its rising edge.
REQ-003 resetb_i  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request to run one permutation on state_i.
REQ-005 mode_i  input  2  round count: 00 = 12 rounds (p^a), 01 = 8 rounds, 10 = 6 rounds (p^b), 11 = reserved.
REQ-006 state_i  input  type_state (5 x 64)  permutation input, sampled only when start is accepted.
REQ-007 state_o  output  type_state  working/result state register.
REQ-008 busy_o  output  1  high while a permutation is in progress.
REQ-009 done_o  output  1  single-cycle pulse; state_o holds the finished result.

Function
REQ-010 FSM states: IDLE, RUN, DONE.
REQ-011 IDLE or DONE with start_i=1: load state_i into the state register, load the round counter with its first round, go to RUN.
REQ-012 First round: 0 for 12 rounds, 4 for 8 rounds, 6 for 6 rounds; mode 11 behaves as mode 00.
REQ-013 Each RUN cycle applies UNROLL consecutive rounds (round r, then r+1) and increments the counter by UNROLL.
REQ-014 A round = constant addition (x2 low byte XOR RC[r], RC[r] = 8'hF0 - r*8'h0F, i.e. F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B), then the 5-bit S-box layer, then linear diffusion with the standard ASCON rotations (19/28, 61/39, 1/6, 10/17, 7/41).
REQ-015 RUN to DONE on the edge where the updated counter equals 12; no counter wrap beyond 12.
REQ-016 Latency: with start accepted at edge 0, exactly N = rounds/UNROLL RUN cycles follow; done_o is high for the single cycle after edge N.
REQ-017 DONE to IDLE after one cycle unless start_i=1 (back-to-back: DONE to RUN, no idle gap).
REQ-018 start_i during RUN is ignored; state_i and mode_i are don't-care outside accepted start.
REQ-019 busy_o = 1 in RUN only; done_o = 1 in DONE only.
REQ-020 state_o holds its value in IDLE and DONE; it is updated only on a load or a RUN edge.

Reset
REQ-021 resetb_i low asynchronously forces IDLE, counter 0, state_o all-zero, busy_o 0, done_o 0.
REQ-022 Reset during RUN abandons the permutation; no done_o pulse follows release.
REQ-023 The first start is accepted on the first rising edge with resetb_i high.

Structure
REQ-024 type_state, the round-constant table, and the mode encodings live in ascon_pack.
REQ-025 One combinational sub-module ascon_round (state in, 4-bit round index in, state out) performs constant addition, substitution and diffusion; it is instantiated UNROLL times in chain.
REQ-026 The FSM, round counter and state register reside in ascon_permutation_seq.

Verification
REQ-027 Reset release, no start -> state_o=0, busy_o=0, done_o=0 indefinitely.
REQ-028 mode 00, UNROLL=1, state_i={80400c0600000000, 0001020304050607, 08090a0b0c0d0e0f, 0011223344556677, 8899aabbccddeeff} -> first-round pre-S-box x2 = 08090a0b0c0d0eff; done_o after exactly 12 RUN cycles; state_o equals golden-model p^12.
REQ-029 Same input, mode 10 and mode 01 -> done_o after 6 and 8 RUN cycles; round indices 6..11 and 4..11; results equal golden p^6/p^8.
REQ-030 UNROLL=2, mode 00 -> done_o after 6 RUN cycles; result identical to the UNROLL=1 run.
REQ-031 start_i pulsed mid-RUN -> ignored, timing and result unchanged; start_i held high through DONE -> new run begins with no idle cycle.
REQ-032 resetb_i low at RUN cycle 3 -> immediate IDLE, state_o=0, no done_o; a fresh start then completes normally.
